// File: rtl/data_mem_latency.sv
// Line-wide backing memory for the data cache: one 256-bit line per request, acked after a fixed latency.
// Optional DMEM_RANGE_CHECK_EN adds err_o, flagging addresses whose bits above the index field are set.
module data_mem_latency #(
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
`ifdef DMEM_RANGE_CHECK_EN
  output logic              err_o,
`endif
  output logic [LINE_W-1:0] data_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int IDX_LO = 5;
  localparam int IDX_HI = IDX_LO + IDX_W - 1;
  localparam logic [7:0] CNT_LAST = 8'(LATENCY - 2);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;
  logic              r_err;
  logic              r_ack;
  logic [LINE_W-1:0] r_rdata;
  logic              w_range_err;
  logic              w_unused;

  logic [LINE_W-1:0] memory [0:DEPTH-1];

  assign w_unused = ^{addr_i[IDX_LO-1:0], addr_i[ADDR_W-1:IDX_HI+1]};

`ifdef DMEM_RANGE_CHECK_EN
  logic r_err_ack;
  assign w_range_err = |addr_i[ADDR_W-1:IDX_HI+1];
  assign err_o       = r_err_ack;
`else
  assign w_range_err = 1'b0;
`endif

  assign ack_o  = r_ack;
  assign data_o = r_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Dropping enable_i in WAIT abandons the request, even on the edge that would enter ACK.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_next = WAIT;
      WAIT: begin
        if (!enable_i)             w_next = IDLE;
        else if (r_cnt == CNT_LAST) w_next = ACK;
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      r_err_ack <= 1'b0;
`endif
    end else begin
      r_ack   <= (w_next == ACK);
      r_rdata <= (w_next == ACK && !r_err) ? memory[r_idx] : '0;
`ifdef DMEM_RANGE_CHECK_EN
      r_err_ack <= (w_next == ACK) && r_err;
`endif
      if (r_state == IDLE && enable_i) begin
        r_cnt   <= '0;
        r_idx   <= addr_i[IDX_HI:IDX_LO];
        r_wdata <= data_i;
        r_write <= write_i;
        r_err   <= w_range_err;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Storage is never cleared; the write commits on the edge that ends the ACK cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_state == ACK && r_write && !r_err)
      memory[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_data_mem_latency.sv
// Scoreboard bench for data_mem_latency: expected lines queued at request time, popped on ack.
module tb_data_mem_latency;

  localparam int LATENCY = 10;
  localparam int DEPTH   = 512;

  typedef struct {
    logic [255:0] data;
    logic         err;
  } sbEntry;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr = '0;
  logic [255:0] dataIn = '0;
  logic         enable = 1'b0;
  logic         write = 1'b0;
  logic         ack;
  logic [255:0] dataOut;
  logic         errOut;

  int     checkCount = 0;
  int     errorCount = 0;
  int     ackCount   = 0;
  bit     monitorOn  = 1'b0;
  sbEntry sbQueue[$];
  logic [255:0] modelMem [0:DEPTH-1];

  data_mem_latency #(.DEPTH(DEPTH), .LINE_W(256), .ADDR_W(32), .LATENCY(LATENCY)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .addr_i(addr),
    .data_i(dataIn),
    .enable_i(enable),
    .write_i(write),
    .ack_o(ack),
`ifdef DMEM_RANGE_CHECK_EN
    .err_o(errOut),
`endif
    .data_o(dataOut)
  );

`ifndef DMEM_RANGE_CHECK_EN
  assign errOut = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] lineOf(input int i);
    return {8{32'hC0DE0000 | 32'(i)}};
  endfunction

  function automatic logic rangeErr(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return |a[31:14];
`else
    return 1'b0;
`endif
  endfunction

  // Builds the expected ack contents and applies any write to the model.
  function automatic sbEntry expectFor(input logic [31:0] a, input logic [255:0] d, input logic wr);
    sbEntry e;
    int idx;
    idx    = int'((a >> 5) % DEPTH);
    e.err  = rangeErr(a);
    e.data = e.err ? '0 : modelMem[idx];
    if (wr && !e.err) modelMem[idx] = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (monitorOn) begin
      if (ack) begin
        ackCount++;
        if (sbQueue.size() == 0) begin
          checkOutput("unexpectedAck", 256'(ack), 256'd0);
        end else begin
          sbEntry e;
          e = sbQueue.pop_front();
          checkOutput("ackData", dataOut, e.data);
          checkOutput("ackErr", 256'(errOut), 256'(e.err));
        end
      end else begin
        checkOutput("idleDataZero", dataOut, 256'd0);
        checkOutput("idleErrZero", 256'(errOut), 256'd0);
      end
    end
  end

  task automatic waitAck(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ack && cycles < 300);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [255:0] d, input logic wr);
    int cycles;
    @(negedge clk);
    sbQueue.push_back(expectFor(a, d, wr));
    addr = a; dataIn = d; write = wr; enable = 1'b1;
    @(posedge clk);
    waitAck(cycles);
    checkOutput("ackLatency", 256'(cycles), 256'(LATENCY));
    enable = 1'b0;
    addr   = $urandom;
    @(negedge clk);
    checkOutput("ackOneCycle", 256'(ack), 256'd0);
  endtask

  // Two requests with enable held high; the second request's inputs appear during the first WAIT.
  task automatic heldPair(input logic [31:0] a1, input logic [255:0] d1, input logic w1,
                          input logic [31:0] a2, input logic [255:0] d2, input logic w2);
    int cycles;
    int gap;
    @(negedge clk);
    sbQueue.push_back(expectFor(a1, d1, w1));
    addr = a1; dataIn = d1; write = w1; enable = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    addr = a2; dataIn = d2; write = w2;
    waitAck(cycles);
    checkOutput("heldLatency", 256'(cycles + 3), 256'(LATENCY));
    sbQueue.push_back(expectFor(a2, d2, w2));
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 3) addr = 32'h0000_0060;
    end while (!ack && gap < 300);
    checkOutput("ackSpacing", 256'(gap), 256'(LATENCY + 1));
    enable = 1'b0;
    @(negedge clk);
    checkOutput("heldOneCycle", 256'(ack), 256'd0);
  endtask

  initial begin
    int acksBefore;
    for (int i = 0; i < DEPTH; i++) begin
      modelMem[i]   = lineOf(i);
      dut.memory[i] = lineOf(i);
    end
    modelMem[0]   = 256'h5;
    dut.memory[0] = 256'h5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetAck", 256'(ack), 256'd0);
    checkOutput("resetData", dataOut, 256'd0);
    rst = 1'b0;
    monitorOn = 1'b1;

    applyStimulus(32'h0000_0000, '0, 1'b0);
    applyStimulus(32'h0000_0400, {32{8'hA5}}, 1'b1);
    applyStimulus(32'h0000_0400, '0, 1'b0);
    checkOutput("mem32", dut.memory[32], {32{8'hA5}});
    checkOutput("mem31", dut.memory[31], lineOf(31));
    checkOutput("mem33", dut.memory[33], lineOf(33));

    heldPair(32'h0000_0020, '0, 1'b0, 32'h0000_0040, '0, 1'b0);

    // Write abandoned by dropping enable after three WAIT cycles.
    acksBefore = ackCount;
    @(negedge clk);
    addr = 32'h0000_0600; dataIn = {32{8'hFF}}; write = 1'b1; enable = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (LATENCY + 5) @(negedge clk);
    checkOutput("abortNoAck", 256'(ackCount), 256'(acksBefore));
    checkOutput("abortMem", dut.memory[48], lineOf(48));

    // Reset during WAIT.
    @(negedge clk);
    addr = 32'h0000_0620; dataIn = {32{8'hEE}}; write = 1'b1; enable = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    checkOutput("rstWaitAck", 256'(ack), 256'd0);
    rst = 1'b0;
    repeat (LATENCY + 3) @(negedge clk);
    checkOutput("rstWaitNoAck", 256'(ackCount), 256'(acksBefore));
    checkOutput("rstWaitMem", dut.memory[49], lineOf(49));

    // Reset during the ACK cycle of a write: acked, but the write is dropped.
    @(negedge clk);
    sbQueue.push_back(expectFor(32'h0000_0640, {32{8'hDD}}, 1'b0));
    addr = 32'h0000_0640; dataIn = {32{8'hDD}}; write = 1'b1; enable = 1'b1;
    @(posedge clk);
    begin
      int cycles;
      waitAck(cycles);
      checkOutput("rstAckLatency", 256'(cycles), 256'(LATENCY));
    end
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    checkOutput("rstAckAck", 256'(ack), 256'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstAckMem", dut.memory[50], lineOf(50));

    applyStimulus(32'h0000_001F, '0, 1'b0);
    applyStimulus(32'h0000_4000, '0, 1'b0);
    applyStimulus(32'h0001_4020, {32{8'h3C}}, 1'b1);
    applyStimulus(32'h0000_0020, '0, 1'b0);

    heldPair(32'h0000_0100, {8{32'hDEADBEEF}}, 1'b1, 32'h0000_0100, '0, 1'b0);
    checkOutput("mem8", dut.memory[8], {8{32'hDEADBEEF}});

    repeat (3) @(negedge clk);
    checkOutput("sbEmpty", 256'(sbQueue.size()), 256'd0);
    monitorOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/data_mem_latency.md
Name: data_mem_latency

Overview:
- Off-chip-style line memory that backs the CPU data cache. Whole 256-bit cache lines are read or written through an enable/ack handshake with a fixed multi-cycle latency.
- Sits between the data-cache controller and the top level.
- The storage array must be named memory so that benches can preload and inspect it hierarchically.

Parameters:
- DEPTH, 512: number of 256-bit lines (16 KB).
- LINE_W, 256: line width in bits.
- ADDR_W, 32: byte-address width.
- LATENCY, 10: cycles from the request being sampled to ack_o; legal range 2..255.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- addr_i  in  ADDR_W  byte address; line index = addr_i[5+log2(DEPTH)-1:5], i.e. [13:5] at the defaults; bits [4:0] ignored.
- data_i  in  LINE_W  write line.
- enable_i  in  1  request valid; held high with addr_i/data_i/write_i stable until ack_o.
- write_i  in  1  1 = write line, 0 = read line.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read line; valid only while ack_o=1.

Behaviour:
- Array memory[0:DEPTH-1] of LINE_W bits. It is not cleared by reset; contents persist across reset.
- FSM states:
  - IDLE: counter = 0.
  - WAIT: counter runs.
  - ACK: one cycle.
- Reset (rst_i=1 at an edge): state IDLE, counter 0, ack_o 0, data_o 0.
- Reset has priority over everything. Reset during WAIT or ACK abandons the transaction, and no write occurs.
- IDLE with enable_i=1 at edge k: go to WAIT, counter 0. Address, data and write are latched at that edge.
- WAIT: counter increments each edge. On the edge where counter reaches LATENCY-2, go to ACK.
  - Result: ack_o is registered and is high during exactly the cycle between edges k+LATENCY-1 and k+LATENCY.
- ACK cycle:
  - ack_o=1.
  - Read: data_o = memory[latched index].
  - Write: memory[latched index] <= latched data at the edge ending the ACK cycle. data_o shows the old content during the ACK cycle.
- ACK always returns to IDLE. enable_i is not sampled during ACK.
  - A requester that keeps enable_i high starts the next transaction at the following edge, so the minimum spacing between acks is LATENCY+1 cycles.
- enable_i dropping during WAIT: abort, return to IDLE, no ack, no write.
- Changes to addr_i, data_i or write_i during WAIT are ignored (latched values are used).
- data_o = 0 whenever ack_o=0.
- Address wrap: address bits above the index field are ignored, so index = (addr>>5) mod DEPTH.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- When defined:
  - Extra output port err_o (1 bit, reset 0).
  - A request whose address bits above the index field are non-zero still completes with the normal timing.
  - In its ACK cycle err_o=1 and data_o=0, and a write is suppressed.
  - err_o=0 on all other cycles.
- When undefined: no err_o port, and the address wraps as described in Behaviour.

Test Plan:
- Reset then read: preload memory[0]=256'h5; read addr 0x0 -> ack_o high in exactly one cycle, LATENCY cycles after the request edge, with data_o=256'h5; data_o=0 on every other cycle.
- Write then read: write 256'hA5..A5 to 0x0400, then read 0x0400 -> data matches; memory[32]=256'hA5..A5; memory[31] and memory[33] unchanged.
- Held enable: enable_i held high across two reads of 0x20 and 0x40 -> acks LATENCY+1 cycles apart with the correct lines; addr_i change during WAIT has no effect.
- Abort and reset: enable_i dropped after 3 WAIT cycles of a write -> no ack, memory unchanged; rst_i asserted mid-transaction -> ack_o=0 the next cycle, no write.
- Offset/wrap: read 0x001F returns line 0; read 0x4000 returns line 0 (without the macro) or err_o=1 with data 0 (with DMEM_RANGE_CHECK_EN).
- Back-to-back write/read to the same line: the read returns the newly written data.
